instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder_pkg.sv | 35 +++
 rtl/instr_encoder_imm_pack.sv | 35 +++
 rtl/instr_encoder.sv | 79 +++++++
 tb/tb_instr_encoder.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/instr_encoder_pkg.sv
// instr_encoder_pkg: instruction classes, opcodes and immediate limits shared with decode
package instr_encoder_pkg;
   typedef enum logic [3:0] {
      K_LOAD, K_STORE, K_RTYPE, K_ITYPE, K_BRANCH, K_LUI, K_AUIPC, K_JAL, K_JALR
   } kind_e;
   typedef enum logic [1:0] {S_IDLE, S_ENC, S_WR} state_e;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam int I_BITS = 12;
   localparam int B_BITS = 13;
   localparam int J_BITS = 21;
   function automatic logic fits(input logic [31:0] v, input int nbits);
      int lim;
      lim = 1 << (nbits - 1);
      return $signed(v) >= -lim && $signed(v) < lim;
   endfunction
   function automatic logic [6:0] opcode_of(input logic [3:0] k);
      return k == K_LOAD   ? OP_LOAD   :
             k == K_STORE  ? OP_STORE  :
             k == K_RTYPE  ? OP_RTYPE  :
             k == K_ITYPE  ? OP_ITYPE  :
             k == K_BRANCH ? OP_BRANCH :
             k == K_LUI    ? OP_LUI    :
             k == K_AUIPC  ? OP_AUIPC  :
             k == K_JAL    ? OP_JAL    :
             k == K_JALR   ? OP_JALR   : 7'b0;
   endfunction
endpackage

// File: rtl/instr_encoder_imm_pack.sv
// imm_pack: places immediate bits at their instruction positions and checks range
module imm_pack
   import instr_encoder_pkg::*;
(
   input  logic [3:0]  kind,
   input  logic [31:0] imm,
   output logic [31:0] ibits,
   output logic        legal
);
   always_comb begin
      ibits = '0;
      legal = 1'b1;
      case (kind)
         K_LOAD, K_ITYPE, K_JALR: begin
            ibits = {imm[11:0], 20'b0};
            legal = fits(imm, I_BITS);
         end
         K_STORE: begin
            ibits = {imm[11:5], 13'b0, imm[4:0], 7'b0};
            legal = fits(imm, I_BITS);
         end
         K_BRANCH: begin
            ibits = {imm[12], imm[10:5], 13'b0, imm[4:1], imm[11], 7'b0};
            legal = fits(imm, B_BITS) && !imm[0];
         end
         K_LUI, K_AUIPC: ibits = {imm[31:12], 12'b0};
         K_JAL: begin
            ibits = {imm[20], imm[10:1], imm[11], imm[19:12], 12'b0};
            legal = fits(imm, J_BITS) && !imm[0];
         end
         K_RTYPE: legal = 1'b1;
         default: legal = 1'b0;
      endcase
   end
endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: encodes RV32I requests and writes them to consecutive instruction-memory words
module instr_encoder
   import instr_encoder_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [3:0]  req_kind,
   input  logic [2:0]  req_funct3,
   input  logic        req_funct7b5,
   input  logic [4:0]  req_rd,
   input  logic [4:0]  req_rs1,
   input  logic [4:0]  req_rs2,
   input  logic [31:0] req_imm,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [15:0] instr_count,
   output logic        err
);
   state_e state, nxt;
   logic [3:0] kind;
   logic [2:0] f3;
   logic f7b5, legal, f7_sel, no_rd, upper, has_rs2;
   logic [4:0] rd, rs1, rs2;
   logic [31:0] imm, ibits, raw, word;
   imm_pack u_imm (.kind(kind), .imm(imm), .ibits(ibits), .legal(legal));
   assign no_rd   = kind == K_STORE || kind == K_BRANCH;
   assign upper   = kind == K_LUI || kind == K_AUIPC || kind == K_JAL;
   assign has_rs2 = kind == K_RTYPE || no_rd;
   assign f7_sel  = kind == K_RTYPE || (kind == K_ITYPE && f3[1:0] == 2'b01);
   assign raw = ibits
              | (no_rd ? 32'b0 : {20'b0, rd, 7'b0})
              | (upper ? 32'b0 : {12'b0, rs1, (kind == K_JALR ? 3'b0 : f3), 12'b0})
              | (has_rs2 ? {7'b0, rs2, 20'b0} : 32'b0)
              | {25'b0, opcode_of(kind)};
   assign word = {raw[31], f7_sel ? f7b5 : raw[30], raw[29:0]};
   always_ff @(posedge clk or posedge reset)
      if (reset) state <= S_IDLE;
      else state <= nxt;
   always_comb begin
      nxt = clear ? S_IDLE :
            state == S_IDLE ? (req_valid ? S_ENC : S_IDLE) :
            state == S_ENC && legal ? S_WR : S_IDLE;
   end
   always_comb begin
      req_ready = state == S_IDLE && !clear && !reset;
      mem_we    = state == S_WR && !clear && !reset;
   end
   always_ff @(posedge clk)
      if (req_valid && req_ready) begin
         kind <= req_kind;
         f3   <= req_funct3;
         f7b5 <= req_funct7b5;
         rd   <= req_rd;
         rs1  <= req_rs1;
         rs2  <= req_rs2;
         imm  <= req_imm;
      end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         mem_addr    <= '0;
         mem_wdata   <= '0;
         instr_count <= '0;
         err         <= 1'b0;
      end else if (clear) begin
         mem_addr    <= '0;
         instr_count <= '0;
         err         <= 1'b0;
      end else if (state == S_ENC) begin
         mem_wdata <= word;
         err       <= err | !legal;
      end else if (state == S_WR) begin
         mem_addr    <= mem_addr + 32'd4;
         instr_count <= instr_count + {15'b0, instr_count != 16'hFFFF};
      end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed and random requests checked against an RV32I encoding model
module tb_instr_encoder;
   logic clk = 1'b0, reset = 1'b1, clear = 1'b0, req_valid = 1'b0, req_ready;
   logic [3:0] req_kind = '0;
   logic [2:0] req_funct3 = '0;
   logic req_funct7b5 = 1'b0;
   logic [4:0] req_rd = '0, req_rs1 = '0, req_rs2 = '0;
   logic [31:0] req_imm = '0;
   logic mem_we, err;
   logic [31:0] mem_addr, mem_wdata;
   logic [15:0] instr_count;
   int checks = 0, failures = 0;
   logic [31:0] exp_addr = '0, last_wdata = '0, last_addr = '0;
   logic [15:0] exp_count = '0;
   logic exp_err = 1'b0;
   instr_encoder dut (
      .clk(clk), .reset(reset), .clear(clear), .req_valid(req_valid), .req_ready(req_ready),
      .req_kind(req_kind), .req_funct3(req_funct3), .req_funct7b5(req_funct7b5),
      .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .instr_count(instr_count), .err(err)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask
   function automatic void model(input logic [3:0] k, input logic [2:0] f3, input logic f7,
                                 input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [31:0] imm, output logic [31:0] w, output logic ok);
      int s;
      s = $signed(imm);
      ok = 1'b1;
      w = '0;
      case (k)
         4'd0: begin ok = s >= -2048 && s < 2048; w = {imm[11:0], rs1, f3, rd, 7'b0000011}; end
         4'd1: begin ok = s >= -2048 && s < 2048; w = {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011}; end
         4'd2: w = {1'b0, f7, 5'b0, rs2, rs1, f3, rd, 7'b0110011};
         4'd3: begin
            ok = s >= -2048 && s < 2048;
            w = {imm[11], (f3 == 3'd1 || f3 == 3'd5) ? f7 : imm[10], imm[9:0], rs1, f3, rd, 7'b0010011};
         end
         4'd4: begin
            ok = s >= -4096 && s < 4096 && !imm[0];
            w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
         end
         4'd5: w = {imm[31:12], rd, 7'b0110111};
         4'd6: w = {imm[31:12], rd, 7'b0010111};
         4'd7: begin
            ok = s >= -(1 << 20) && s < (1 << 20) && !imm[0];
            w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
         end
         4'd8: begin ok = s >= -2048 && s < 2048; w = {imm[11:0], rs1, 3'b000, rd, 7'b1100111}; end
         default: ok = 1'b0;
      endcase
   endfunction
   task automatic drive(input logic [3:0] k, input logic [2:0] f3, input logic f7, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
      req_valid = 1'b1;
      req_kind = k;
      req_funct3 = f3;
      req_funct7b5 = f7;
      req_rd = rd;
      req_rs1 = rs1;
      req_rs2 = rs2;
      req_imm = imm;
   endtask
   task automatic do_req(input logic [3:0] k, input logic [2:0] f3, input logic f7, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
      logic [31:0] w;
      logic ok;
      model(k, f3, f7, rd, rs1, rs2, imm, w, ok);
      @(negedge clk);
      check("ready_idle", {31'b0, req_ready}, 32'd1);
      drive(k, f3, f7, rd, rs1, rs2, imm);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      check("ready_busy", {31'b0, req_ready}, 32'd0);
      check("we_n1", {31'b0, mem_we}, 32'd0);
      @(posedge clk);
      #1;
      if (ok) begin
         check("we_n2", {31'b0, mem_we}, 32'd1);
         check("addr", mem_addr, exp_addr);
         check("wdata", mem_wdata, w);
         last_wdata = mem_wdata;
         last_addr = mem_addr;
         exp_addr = exp_addr + 32'd4;
         exp_count = exp_count == 16'hFFFF ? exp_count : exp_count + 16'd1;
      end else begin
         check("we_illegal", {31'b0, mem_we}, 32'd0);
         exp_err = 1'b1;
      end
      @(posedge clk);
      #1;
      check("we_after", {31'b0, mem_we}, 32'd0);
      check("count", {16'b0, instr_count}, {16'b0, exp_count});
      check("err", {31'b0, err}, {31'b0, exp_err});
      check("addr_after", mem_addr, exp_addr);
   endtask
   initial begin
      logic [31:0] imm;
      logic [31:0] edges [10];
      logic [3:0] k;
      edges = '{32'd2047, 32'd2048, -32'sd2048, -32'sd2049, 32'd4094, 32'd4096,
                -32'sd4096, 32'd1048574, 32'd1048576, -32'sd1048576};
      #12;
      check("rst_ready", {31'b0, req_ready}, 32'd0);
      check("rst_we", {31'b0, mem_we}, 32'd0);
      check("rst_addr", mem_addr, 32'd0);
      check("rst_wdata", mem_wdata, 32'd0);
      check("rst_count", {16'b0, instr_count}, 32'd0);
      check("rst_err", {31'b0, err}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      do_req(4'd3, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
      check("itype_word", last_wdata, 32'h00500093);
      check("itype_addr", last_addr, 32'h0);
      check("itype_count", {16'b0, instr_count}, 32'd1);
      do_req(4'd1, 3'b010, 1'b0, 5'd0, 5'd0, 5'd2, 32'd8);
      check("store_word", last_wdata, 32'h00202423);
      do_req(4'd7, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd8);
      check("jal_word", last_wdata, 32'h008000EF);
      check("jal_addr", last_addr, 32'h8);
      do_req(4'd2, 3'b000, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0);
      check("rtype_word", last_wdata, 32'h402081B3);
      do_req(4'd4, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 32'd3);
      check("branch_err", {31'b0, err}, 32'd1);
      check("branch_count", {16'b0, instr_count}, 32'd4);
      do_req(4'd5, 3'b000, 1'b0, 5'd7, 5'd0, 5'd0, 32'hABCDE123);
      check("lui_word", last_wdata, 32'hABCDE3B7);
      for (int i = 0; i < 300; i++) begin
         k = $urandom_range(0, 9) == 0 ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
         case ($urandom_range(0, 3))
            0: imm = $urandom;
            1: imm = 32'($urandom_range(0, 8191)) - 32'd4096;
            2: imm = edges[$urandom_range(0, 9)];
            default: imm = 32'($urandom_range(0, 1023)) << 1;
         endcase
         repeat ($urandom_range(0, 2)) @(negedge clk);
         do_req(k, 3'($urandom), 1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), imm);
      end
      @(negedge clk);
      drive(4'd3, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
      @(posedge clk);
      #1;
      @(negedge clk);
      clear = 1'b1;
      @(posedge clk);
      #1;
      exp_addr = '0;
      exp_count = '0;
      exp_err = 1'b0;
      check("clr_we", {31'b0, mem_we}, 32'd0);
      check("clr_addr", mem_addr, 32'd0);
      check("clr_count", {16'b0, instr_count}, 32'd0);
      check("clr_err", {31'b0, err}, 32'd0);
      check("clr_ready", {31'b0, req_ready}, 32'd0);
      @(posedge clk);
      #1;
      check("clr_hold_we", {31'b0, mem_we}, 32'd0);
      @(negedge clk);
      clear = 1'b0;
      req_valid = 1'b0;
      #1;
      check("clr_rel_ready", {31'b0, req_ready}, 32'd1);
      repeat (2) begin
         @(posedge clk);
         #1;
         check("clr_nowrite", {31'b0, mem_we}, 32'd0);
      end
      check("clr_addr_end", mem_addr, 32'd0);
      do_req(4'd0, 3'b010, 1'b0, 5'd4, 5'd2, 5'd0, 32'd16);
      @(negedge clk);
      drive(4'd3, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(posedge clk);
      #1;
      check("wr_we", {31'b0, mem_we}, 32'd1);
      #1;
      reset = 1'b1;
      #1;
      check("rstwr_we", {31'b0, mem_we}, 32'd0);
      check("rstwr_addr", mem_addr, 32'd0);
      check("rstwr_count", {16'b0, instr_count}, 32'd0);
      check("rstwr_wdata", mem_wdata, 32'd0);
      check("rstwr_ready", {31'b0, req_ready}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("rstrel_ready", {31'b0, req_ready}, 32'd1);
      @(posedge clk);
      #1;
      check("rstrel_we", {31'b0, mem_we}, 32'd0);
      check("rstrel_addr", mem_addr, 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
